ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync_edge.sv | 40 ++++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command bytes and response bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_ECHO      = 8'hEE;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a falling-edge
// strobe on the synchronized clock; shared by the host transmitter and the receiver.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        meta_d     = {dat_in, clk_in};
        sync_d     = meta_q;
        clk_prev_d = sync_q[0];
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_sync = sync_q[0];
    assign dat_sync = sync_q[1];
    assign clk_fall = clk_prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the start bit, shifts
// data/parity/stop on device clock falls and checks the device ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       busy,
    output logic       txDone,
    output logic       txError,
    input  logic       ps2ClkIn,
    input  logic       ps2DatIn,
    output logic       ps2ClkOe,
    output logic       ps2DatOe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state_q, state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          clk_sync, dat_sync, clk_fall;
    logic          tmo_active, tmo_hit;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (ps2ClkIn),
        .dat_in   (ps2DatIn),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_fall (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        tmo_d     = tmo_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        txDone    = 1'b0;
        txError   = 1'b0;

        // The device watchdog only runs once the bus has been handed to the device.
        tmo_active = (state_q == ST_START) || (state_q == ST_SHIFT) ||
                     (state_q == ST_ACK)   || (state_q == ST_WAIT_IDLE);
        tmo_hit    = tmo_active && !clk_fall && (tmo_q == TMO_LAST);
        if (tmo_active) begin
            tmo_d = clk_fall ? '0 : tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (txValid) begin
                    data_d    = txData;
                    parity_d  = odd_parity(txData);
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b1;
                    tmo_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                end
            end
            ST_START: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    if (bit_idx_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end else begin
                        if (bit_idx_q == 4'd8) begin
                            dat_oe_d = ~parity_q;
                        end else begin
                            dat_oe_d = ~data_q[bit_idx_q[2:0]];
                        end
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (dat_sync) begin
                        txError = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    txDone  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled device overrides everything: release the bus and report.
        if (tmo_hit) begin
            txDone   = 1'b0;
            txError  = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            inh_cnt_q <= '0;
            tmo_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_q     <= tmo_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    assign txReady  = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign ps2ClkOe = clk_oe_q;
    assign ps2DatOe = dat_oe_q;

endmodule
